// File: rtl/l2_fwd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : l2_fwd_pkg                                           |
// | Description : Shared constants, FSM state type and mask helpers    |
// |               for the L2 MAC learning / forwarding table.          |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
package l2_fwd_pkg;

   localparam int MAC_W     = 48;
   localparam int IG_BIT    = 40;   // individual/group bit of the first octet
   localparam int MAX_PORTS = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_UPDATE = 2'd2,
      ST_RESP   = 2'd3
   } fwd_state_t;

   // Multicast / broadcast addresses have the I/G bit set.
   function automatic logic is_group(input logic [MAC_W-1:0] mac);
      return mac[IG_BIT];
   endfunction

   // All existing ports except the ingress port; callers truncate to PORT_NUM.
   function automatic logic [MAX_PORTS-1:0] flood_mask(input logic [3:0] src_port,
                                                        input int       port_num);
      logic [MAX_PORTS-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         if ((i < port_num) && (i != int'(src_port))) begin
            m[i] = 1'b1;
         end
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/l2_fwd_table_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : l2_fwd_table_if                                      |
// | Description : Lookup request / forwarding response handshake bus   |
// |               between the header reader and the forwarding table.  |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
interface l2_fwd_table_if #(
   parameter int PORT_NUM = 4
);
   import l2_fwd_pkg::*;

   localparam int PW = $clog2(PORT_NUM);

   logic                req_valid;
   logic                req_ready;
   logic [MAC_W-1:0]    req_dst_mac;
   logic [MAC_W-1:0]    req_src_mac;
   logic [PW-1:0]       req_src_port;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [PORT_NUM-1:0] rsp_port_mask;
   logic                rsp_hit;

   // Requester side (header FIFO reader / egress writer)
   modport master (
      output req_valid, req_dst_mac, req_src_mac, req_src_port, rsp_ready,
      input  req_ready, rsp_valid, rsp_port_mask, rsp_hit
   );

   // Table side
   modport slave (
      input  req_valid, req_dst_mac, req_src_mac, req_src_port, rsp_ready,
      output req_ready, rsp_valid, rsp_port_mask, rsp_hit
   );

endinterface
`default_nettype wire

// File: rtl/l2_fwd_table.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : l2_fwd_table                                         |
// | Description : MAC learning and forwarding table. Sequentially      |
// |               scans all entries per header, learns the source,     |
// |               and returns the egress port mask. Supports aging,    |
// |               flush and group-address flooding.                    |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module l2_fwd_table
   import l2_fwd_pkg::*;
#(
   parameter int PORT_NUM = 4,
   parameter int ADDR_LEN = 3,
   parameter int AGE_W    = 4
) (
   input  wire logic                clk,
   input  wire logic                rst,
   l2_fwd_table_if.slave            bus,
   input  wire logic [PORT_NUM-1:0] mask_port,
   input  wire logic                age_tick,
   input  wire logic                flush,
   output logic      [ADDR_LEN:0]   occupancy
);

   localparam int                DEPTH   = 1 << ADDR_LEN;
   localparam int                PW      = $clog2(PORT_NUM);
   localparam logic [AGE_W-1:0]  AGE_MAX = {AGE_W{1'b1}};
   localparam logic [ADDR_LEN-1:0] LAST_IDX = ADDR_LEN'(DEPTH - 1);

   // Table storage: flat registers so the whole table can age in one cycle
   logic                r_valid [DEPTH];
   logic [MAC_W-1:0]    r_mac   [DEPTH];
   logic [PW-1:0]       r_port  [DEPTH];
   logic [AGE_W-1:0]    r_age   [DEPTH];

   fwd_state_t          r_state;
   logic                r_flush_pend;
   logic                r_age_pend;
   logic [ADDR_LEN-1:0] r_idx;
   logic [ADDR_LEN-1:0] r_victim_ptr;

   // Latched request
   logic [MAC_W-1:0]    r_dst;
   logic [MAC_W-1:0]    r_src;
   logic [PW-1:0]       r_src_port;

   // Scan results
   logic                r_dst_hit;
   logic [PW-1:0]       r_dst_port;
   logic                r_src_hit;
   logic [ADDR_LEN-1:0] r_src_idx;
   logic                r_free_hit;
   logic [ADDR_LEN-1:0] r_free_idx;

   logic                w_dst_group;
   logic                w_src_group;
   logic [PORT_NUM-1:0] w_flood;
   logic [PORT_NUM-1:0] w_onehot;
   logic [PORT_NUM-1:0] w_mask_sel;
   logic [ADDR_LEN-1:0] w_learn_idx;
   logic [ADDR_LEN:0]   w_count;

   assign bus.req_ready = (r_state == ST_IDLE) && !r_flush_pend && !r_age_pend;

   // Forwarding decision and learning target from the completed scan
   always_comb begin
      w_dst_group = is_group(r_dst);
      w_src_group = is_group(r_src);
      w_flood     = PORT_NUM'(flood_mask(4'(r_src_port), PORT_NUM));
      w_onehot    = {{(PORT_NUM-1){1'b0}}, 1'b1} << r_dst_port;
      if (w_dst_group || !r_dst_hit) begin
         w_mask_sel = w_flood;
      end else if (r_dst_port == r_src_port) begin
         w_mask_sel = '0;          // destination is behind the ingress port
      end else begin
         w_mask_sel = w_onehot;
      end
      if (r_src_hit) begin
         w_learn_idx = r_src_idx;
      end else if (r_free_hit) begin
         w_learn_idx = r_free_idx;
      end else begin
         w_learn_idx = r_victim_ptr;
      end
   end

   // Population count of the valid bits
   always_comb begin
      w_count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_count = w_count + (ADDR_LEN+1)'(r_valid[i]);
      end
   end

   // Registered occupancy, one cycle behind any table write
   always_ff @(posedge clk) begin
      if (rst) begin
         occupancy <= '0;
      end else begin
         occupancy <= w_count;
      end
   end

   // Main FSM: request scan, learning, response handshake, aging and flush
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state           <= ST_IDLE;
         r_flush_pend      <= 1'b0;
         r_age_pend        <= 1'b0;
         r_idx             <= '0;
         r_victim_ptr      <= '0;
         r_dst             <= '0;
         r_src             <= '0;
         r_src_port        <= '0;
         r_dst_hit         <= 1'b0;
         r_dst_port        <= '0;
         r_src_hit         <= 1'b0;
         r_src_idx         <= '0;
         r_free_hit        <= 1'b0;
         r_free_idx        <= '0;
         bus.rsp_valid     <= 1'b0;
         bus.rsp_port_mask <= '0;
         bus.rsp_hit       <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
         end
      end else begin
         // Strobes are remembered in any state; applying one clears it below
         if (flush) begin
            r_flush_pend <= 1'b1;
         end
         if (age_tick) begin
            r_age_pend <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (r_flush_pend) begin
                  r_flush_pend <= 1'b0;
                  for (int i = 0; i < DEPTH; i++) begin
                     r_valid[i] <= 1'b0;
                  end
               end else if (r_age_pend) begin
                  r_age_pend <= 1'b0;
                  for (int i = 0; i < DEPTH; i++) begin
                     if (r_valid[i]) begin
                        if (r_age[i] == AGE_W'(1)) begin
                           r_valid[i] <= 1'b0;
                        end else if (r_age[i] != '0) begin
                           r_age[i] <= r_age[i] - AGE_W'(1);
                        end
                     end
                  end
               end else if (bus.req_valid) begin
                  r_dst      <= bus.req_dst_mac;
                  r_src      <= bus.req_src_mac;
                  r_src_port <= bus.req_src_port;
                  r_idx      <= '0;
                  r_dst_hit  <= 1'b0;
                  r_src_hit  <= 1'b0;
                  r_free_hit <= 1'b0;
                  r_state    <= ST_SCAN;
               end
            end

            ST_SCAN: begin
               if (r_valid[r_idx]) begin
                  if (!r_dst_hit && (r_mac[r_idx] == r_dst)) begin
                     r_dst_hit  <= 1'b1;
                     r_dst_port <= r_port[r_idx];
                  end
                  if (!r_src_hit && (r_mac[r_idx] == r_src)) begin
                     r_src_hit <= 1'b1;
                     r_src_idx <= r_idx;
                  end
               end else if (!r_free_hit) begin
                  r_free_hit <= 1'b1;
                  r_free_idx <= r_idx;
               end
               if (r_idx == LAST_IDX) begin
                  r_state <= ST_UPDATE;
               end else begin
                  r_idx <= r_idx + ADDR_LEN'(1);
               end
            end

            ST_UPDATE: begin
               // Group sources are never learned
               if (!w_src_group) begin
                  r_valid[w_learn_idx] <= 1'b1;
                  r_mac[w_learn_idx]   <= r_src;
                  r_port[w_learn_idx]  <= r_src_port;
                  r_age[w_learn_idx]   <= AGE_MAX;
                  if (!r_src_hit && !r_free_hit) begin
                     r_victim_ptr <= r_victim_ptr + ADDR_LEN'(1);
                  end
               end
               bus.rsp_port_mask <= w_mask_sel & ~mask_port;
               bus.rsp_hit       <= r_dst_hit && !w_dst_group;
               bus.rsp_valid     <= 1'b1;
               r_state           <= ST_RESP;
            end

            ST_RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  r_state       <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_l2_fwd_table.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_l2_fwd_table                                      |
// | Description : Scoreboard bench for l2_fwd_table (4 ports, 8        |
// |               entries, 4-bit age).                                 |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module tb_l2_fwd_table;

   localparam int DEPTH = 8;

   localparam logic [47:0] MAC_A  = 48'h02000000000A;
   localparam logic [47:0] MAC_B  = 48'h02000000000B;
   localparam logic [47:0] MAC_C  = 48'h02000000000C;
   localparam logic [47:0] MAC_I  = 48'h020000000012;
   localparam logic [47:0] MAC_J  = 48'h020000000013;
   localparam logic [47:0] G_SRC  = 48'h01005E000001;
   localparam logic [47:0] G_DST  = 48'h01005E000002;
   localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;

   typedef struct {
      logic [3:0] mask;
      logic       hit;
      int         t_acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] mask_port;
   logic       age_tick;
   logic       flush;
   logic [3:0] occupancy;

   int   cyc     = 0;
   int   n_pass  = 0;
   int   n_total = 0;
   exp_t q[$];

   l2_fwd_table_if #(.PORT_NUM(4)) bus ();

   l2_fwd_table #(.PORT_NUM(4), .ADDR_LEN(3), .AGE_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mask_port (mask_port),
      .age_tick  (age_tick),
      .flush     (flush),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor: pops the scoreboard on each new response and checks hold stability
   logic       prev_v = 1'b0;
   logic [3:0] held_mask;
   logic       held_hit;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (bus.rsp_valid && !prev_v) begin
            chk("rsp_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("rsp_mask", 64'(bus.rsp_port_mask), 64'(e.mask));
               chk("rsp_hit", 64'(bus.rsp_hit), 64'(e.hit));
               chk("rsp_latency", 64'(cyc - e.t_acc), 64'(DEPTH + 2));
            end
            held_mask = bus.rsp_port_mask;
            held_hit  = bus.rsp_hit;
         end else if (bus.rsp_valid) begin
            chk("rsp_mask_stable", 64'(bus.rsp_port_mask), 64'(held_mask));
            chk("rsp_hit_stable", 64'(bus.rsp_hit), 64'(held_hit));
         end
         prev_v = bus.rsp_valid;
      end
   end

   // Issue one lookup and complete its response handshake
   task automatic send(input logic [47:0] dst, input logic [47:0] src, input logic [1:0] port,
                       input logic [3:0] m, input logic h, input int hold, input bit strobe);
      bit   ok;
      exp_t e;
      @(posedge clk); #1;
      bus.req_valid    = 1'b1;
      bus.req_dst_mac  = dst;
      bus.req_src_mac  = src;
      bus.req_src_port = port;
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (bus.req_ready) ok = 1'b1;
      end
      chk("req_accept", 64'(ok), 64'd1);
      if (!ok) begin
         bus.req_valid = 1'b0;
         return;
      end
      e.mask  = m;
      e.hit   = h;
      e.t_acc = cyc;
      q.push_back(e);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      if (hold > 0) bus.rsp_ready = 1'b0;
      if (strobe) begin
         flush    = 1'b1;
         age_tick = 1'b1;
         @(posedge clk); #1;
         flush    = 1'b0;
         age_tick = 1'b0;
      end
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (bus.rsp_valid) ok = 1'b1;
      end
      chk("rsp_arrives", 64'(ok), 64'd1);
      if (!ok) begin
         bus.rsp_ready = 1'b1;
         return;
      end
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1;
         bus.rsp_ready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
   endtask

   task automatic occ_chk(input string name, input logic [3:0] exp);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk(name, 64'(occupancy), 64'(exp));
   endtask

   task automatic pulse(input bit do_flush, input bit do_age);
      @(posedge clk); #1;
      flush    = do_flush;
      age_tick = do_age;
      @(posedge clk); #1;
      flush    = 1'b0;
      age_tick = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      rst              = 1'b1;
      mask_port        = 4'b0000;
      age_tick         = 1'b0;
      flush            = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_dst_mac  = '0;
      bus.req_src_mac  = '0;
      bus.req_src_port = '0;
      bus.rsp_ready    = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
      chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("reset_rsp_mask", 64'(bus.rsp_port_mask), 64'd0);
      chk("reset_rsp_hit", 64'(bus.rsp_hit), 64'd0);
      chk("reset_occupancy", 64'(occupancy), 64'd0);

      // Learning and unicast forwarding
      send(MAC_B, MAC_A, 2'd1, 4'b1101, 1'b0, 0, 1'b0);
      occ_chk("occ_after_A", 4'd1);
      send(MAC_A, MAC_B, 2'd2, 4'b0010, 1'b1, 0, 1'b0);
      occ_chk("occ_after_B", 4'd2);
      send(MAC_A, MAC_A, 2'd1, 4'b0000, 1'b1, 0, 1'b0);
      occ_chk("occ_after_refresh", 4'd2);

      // Broadcast with a masked port, then a group source that must not learn
      mask_port = 4'b0100;
      send(BCAST, MAC_C, 2'd0, 4'b1010, 1'b0, 0, 1'b0);
      mask_port = 4'b0000;
      occ_chk("occ_after_C", 4'd3);
      send(MAC_B, G_SRC, 2'd3, 4'b0100, 1'b1, 0, 1'b0);
      occ_chk("occ_group_src", 4'd3);

      // Fill the table, then replace round-robin from entry 0
      for (int k = 0; k < 5; k++) begin
         send(G_DST, 48'h02000000000D + 48'(k), 2'd3, 4'b0111, 1'b0, 0, 1'b0);
      end
      occ_chk("occ_full", 4'd8);
      send(G_DST, MAC_I, 2'd3, 4'b0111, 1'b0, 0, 1'b0);
      occ_chk("occ_after_victim", 4'd8);
      send(MAC_A, G_SRC, 2'd3, 4'b0111, 1'b0, 0, 1'b0);   // entry 0 gone
      send(MAC_I, G_SRC, 2'd0, 4'b1000, 1'b1, 0, 1'b0);
      send(G_DST, MAC_J, 2'd3, 4'b0111, 1'b0, 0, 1'b0);   // replaces entry 1
      send(MAC_B, G_SRC, 2'd0, 4'b1110, 1'b0, 0, 1'b0);
      send(MAC_C, G_SRC, 2'd3, 4'b0001, 1'b1, 0, 1'b0);

      // Flush, learn one entry, then age it out
      pulse(1'b1, 1'b0);
      occ_chk("occ_after_flush", 4'd0);
      send(G_DST, MAC_A, 2'd1, 4'b1101, 1'b0, 0, 1'b0);
      occ_chk("occ_aging_start", 4'd1);
      for (int k = 0; k < 14; k++) pulse(1'b0, 1'b1);
      occ_chk("occ_after_14_ticks", 4'd1);
      send(MAC_A, G_SRC, 2'd0, 4'b0010, 1'b1, 0, 1'b0);
      pulse(1'b0, 1'b1);
      occ_chk("occ_after_15_ticks", 4'd0);
      send(MAC_A, G_SRC, 2'd0, 4'b1110, 1'b0, 0, 1'b0);

      // Flush and age strobes during a scan with a stalled consumer
      send(G_DST, MAC_A, 2'd1, 4'b1101, 1'b0, 0, 1'b0);
      occ_chk("occ_before_stall", 4'd1);
      send(MAC_A, G_SRC, 2'd0, 4'b0010, 1'b1, 5, 1'b1);
      @(negedge clk);
      chk("ready_low_flush_cycle", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      chk("ready_low_age_cycle", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      chk("ready_high_after_pend", 64'(bus.req_ready), 64'd1);
      chk("occ_after_deferred_flush", 64'(occupancy), 64'd0);

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
